// File: rtl/alu_serie_seq.sv
// -----------------------------------------------------------------------------
// alu_serie_seq -- bit-serial N-bit ALU sequencer around a single 1-bit cal cell
//
// One operand bit pair is fed through the cal cell per cycle, LSB first. An
// N-bit result takes N+2 cycles from the accepted start to the return to IDLE.
//
// Cal cell logic-op select (s, used when arit = 0):
//   00 AND   01 OR   10 XOR   11 NOT a
// With arit = 1 the cell is a full adder. c_out is always the adder carry.
//
// Ports (alu_serie_seq):
//   clk     in   1  clock, all state on rising edge
//   reset   in   1  synchronous, active-high
//   start   in   1  request pulse, sampled only in IDLE
//   a, b    in   N  operands, captured on accepted start
//   arit    in   1  1 = add, 0 = logic op (captured on start)
//   s       in   2  logic-op select (captured on start)
//   c_in    in   1  carry into bit 0 (captured on start)
//   busy    out  1  high during the N shift cycles
//   done    out  1  one-cycle pulse, result/flags valid
//   result  out  N  assembled result, held until next DONE
//   c_out   out  1  carry out of bit N-1, forced 0 in logic mode
//   zero    out  1  result == 0
// -----------------------------------------------------------------------------

// 1-bit cal cell: logic unit, full adder and output mux.
module alu_serie_cal (
   input  logic       a_i,
   input  logic       b_i,
   input  logic       c_in_i,
   input  logic       arit_i,
   input  logic [1:0] s_i,
   output logic       out_o,
   output logic       c_out_o
);
   logic logic_out;

   always_comb begin
      unique case (s_i)
         2'b00:   logic_out = a_i & b_i;
         2'b01:   logic_out = a_i | b_i;
         2'b10:   logic_out = a_i ^ b_i;
         default: logic_out = ~a_i;
      endcase
   end

   assign out_o   = arit_i ? (a_i ^ b_i ^ c_in_i) : logic_out;
   assign c_out_o = (a_i & b_i) | (c_in_i & (a_i ^ b_i));
endmodule

module alu_serie_seq #(
   parameter int N     = 4,
   parameter int CNT_W = 3
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         arit,
   input  logic [1:0]   s,
   input  logic         c_in,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] result,
   output logic         c_out,
   output logic         zero
);
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

   state_e             state_q,  state_d;
   logic [N-1:0]       a_sh_q,   a_sh_d;
   logic [N-1:0]       b_sh_q,   b_sh_d;
   logic [N-1:0]       res_sh_q, res_sh_d;
   logic               carry_q,  carry_d;
   logic               arit_q,   arit_d;
   logic [1:0]         s_q,      s_d;
   logic [CNT_W-1:0]   cnt_q,    cnt_d;
   logic               done_q,   done_d;
   logic [N-1:0]       result_q, result_d;
   logic               c_out_q,  c_out_d;
   logic               zero_q,   zero_d;

   logic cal_out;
   logic cal_c_out;

   alu_serie_cal u_cal (
      .a_i     (a_sh_q[0]),
      .b_i     (b_sh_q[0]),
      .c_in_i  (carry_q),
      .arit_i  (arit_q),
      .s_i     (s_q),
      .out_o   (cal_out),
      .c_out_o (cal_c_out)
   );

   always_comb begin
      // NOTE: every signal written here gets a default first; a path that
      // leaves one unassigned would infer a latch.
      state_d  = state_q;
      a_sh_d   = a_sh_q;
      b_sh_d   = b_sh_q;
      res_sh_d = res_sh_q;
      carry_d  = carry_q;
      arit_d   = arit_q;
      s_d      = s_q;
      cnt_d    = cnt_q;
      done_d   = 1'b0;
      result_d = result_q;
      c_out_d  = c_out_q;
      zero_d   = zero_q;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               a_sh_d   = a;
               b_sh_d   = b;
               arit_d   = arit;
               s_d      = s;
               carry_d  = c_in;
               cnt_d    = '0;
               res_sh_d = '0;
               state_d  = SHIFT;
            end
         end
         SHIFT: begin
            a_sh_d   = a_sh_q >> 1;
            b_sh_d   = b_sh_q >> 1;
            // Result bits enter at the MSB so bit 0 lands at position 0
            // after exactly N shifts.
            res_sh_d = {cal_out, res_sh_q[N-1:1]};
            carry_d  = cal_c_out;
            cnt_d    = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(N - 1)) state_d = DONE;
         end
         DONE: begin
            done_d   = 1'b1;
            result_d = res_sh_q;
            // The carry chain runs in logic mode too; it is only meaningful
            // for additions.
            c_out_d  = carry_q & arit_q;
            zero_d   = ~|res_sh_q;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge value of the others, independent of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         a_sh_q   <= '0;
         b_sh_q   <= '0;
         res_sh_q <= '0;
         carry_q  <= 1'b0;
         arit_q   <= 1'b0;
         s_q      <= '0;
         cnt_q    <= '0;
         done_q   <= 1'b0;
         result_q <= '0;
         c_out_q  <= 1'b0;
         zero_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_sh_q   <= a_sh_d;
         b_sh_q   <= b_sh_d;
         res_sh_q <= res_sh_d;
         carry_q  <= carry_d;
         arit_q   <= arit_d;
         s_q      <= s_d;
         cnt_q    <= cnt_d;
         done_q   <= done_d;
         result_q <= result_d;
         c_out_q  <= c_out_d;
         zero_q   <= zero_d;
      end
   end

   assign busy   = (state_q == SHIFT);
   assign done   = done_q;
   assign result = result_q;
   assign c_out  = c_out_q;
   assign zero   = zero_q;
endmodule
